hazard_scoreboard: RTL



---
 rtl/hazard_scoreboard_if.sv | 57 +++++
 rtl/hazard_scoreboard.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
// Bundles every D/E-stage signal exchanged between the pipeline and the
// hazard unit. The pipeline side uses the master modport. The hazard
// unit uses the slave modport.
//
// Pipeline -> hazard unit:
//   d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_rs_use, d_rt_use,
//   d_wen, d_dst, d_tnew, d_md_use, d_rs_rf, d_rt_rf,
//   e_rs_in, e_rt_in, stage_wdata, md_start, md_div
//
// Hazard unit -> pipeline:
//   stall, d_rs_fwd, d_rt_fwd, e_rs_fwd, e_rt_fwd, md_busy
interface hazard_scoreboard_if #(
  parameter int NSTAGE = 3,
  parameter int AW     = 5,
  parameter int DW     = 32,
  parameter int TW     = 2
);
  logic                 d_valid;
  logic [AW-1:0]        d_rs;
  logic [AW-1:0]        d_rt;
  logic [TW-1:0]        d_rs_tuse;
  logic [TW-1:0]        d_rt_tuse;
  logic                 d_rs_use;
  logic                 d_rt_use;
  logic                 d_wen;
  logic [AW-1:0]        d_dst;
  logic [TW-1:0]        d_tnew;
  logic                 d_md_use;
  logic [DW-1:0]        d_rs_rf;
  logic [DW-1:0]        d_rt_rf;
  logic [DW-1:0]        e_rs_in;
  logic [DW-1:0]        e_rt_in;
  logic [NSTAGE*DW-1:0] stage_wdata;
  logic                 md_start;
  logic                 md_div;
  logic                 stall;
  logic [DW-1:0]        d_rs_fwd;
  logic [DW-1:0]        d_rt_fwd;
  logic [DW-1:0]        e_rs_fwd;
  logic [DW-1:0]        e_rt_fwd;
  logic                 md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_rs_use, d_rt_use,
           d_wen, d_dst, d_tnew, d_md_use, d_rs_rf, d_rt_rf,
           e_rs_in, e_rt_in, stage_wdata, md_start, md_div,
    input  stall, d_rs_fwd, d_rt_fwd, e_rs_fwd, e_rt_fwd, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_rs_use, d_rt_use,
           d_wen, d_dst, d_tnew, d_md_use, d_rs_rf, d_rt_rf,
           e_rs_in, e_rt_in, stage_wdata, md_start, md_div,
    output stall, d_rs_fwd, d_rt_fwd, e_rs_fwd, e_rt_fwd, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// This is the hazard unit for the in-order MIPS pipeline. A shift-register
// scoreboard tracks the register writes that are in flight across the
// post-decode stages: index 0 is E and index NSTAGE-1 is W. Each entry
// carries a Tnew countdown.
//
// From the scoreboard the unit computes three things:
//   - the D-stage stall
//   - forwarded operands for D
//   - forwarded operands for E
// It also runs the multiply/divide busy counter, and it stalls D-stage
// MDU users while that counter is running.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous, active-low reset
//   bus      hazard_scoreboard_if.slave, which carries all D/E signals
//            (see the interface file for the list)
module hazard_scoreboard #(
  parameter int NSTAGE  = 3,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int TW      = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  hazard_scoreboard_if.slave  bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef struct packed {
    logic          hit;
    logic [TW-1:0] tnew;
    logic [DW-1:0] data;
  } match_t;

  // Scoreboard state.
  // Only entry 0's source addresses are ever consulted, so they are kept
  // as a single pair of registers rather than being shifted down the array.
  logic [NSTAGE-1:0]          ent_wen;
  logic [NSTAGE-1:0][AW-1:0]  ent_dst;
  logic [NSTAGE-1:0][TW-1:0]  ent_tnew;
  logic [AW-1:0]              e_src_rs;
  logic [AW-1:0]              e_src_rt;
  logic [CW-1:0]              md_cnt;

  match_t d_rs_m, d_rt_m, e_rs_m, e_rt_m;
  logic   rs_wait, rt_wait, md_block, md_busy_int, stall_int;

  // Youngest-writer search.
  // The loop walks from oldest to youngest, so the last hit wins and
  // older matches are shadowed. The window mask excludes stages that must
  // not be searched; E forwarding, for example, skips entry 0.
  // Register 0 is never matched.
  function automatic match_t find_youngest(
    input logic [AW-1:0]             addr,
    input logic [NSTAGE-1:0]         window,
    input logic [NSTAGE-1:0]         wen,
    input logic [NSTAGE-1:0][AW-1:0] dst,
    input logic [NSTAGE-1:0][TW-1:0] tnew,
    input logic [NSTAGE*DW-1:0]      wdata
  );
    match_t m;
    m = '0;
    if (addr != '0) begin
      for (int s = NSTAGE - 1; s >= 0; s--) begin
        if (window[s] && wen[s] && dst[s] == addr) begin
          m.hit  = 1'b1;
          m.tnew = tnew[s];
          m.data = wdata[s*DW +: DW];
        end
      end
    end
    return m;
  endfunction

  always_comb begin
    d_rs_m = find_youngest(bus.d_rs, {NSTAGE{1'b1}}, ent_wen, ent_dst,
                           ent_tnew, bus.stage_wdata);
    d_rt_m = find_youngest(bus.d_rt, {NSTAGE{1'b1}}, ent_wen, ent_dst,
                           ent_tnew, bus.stage_wdata);
    e_rs_m = find_youngest(e_src_rs, {{(NSTAGE-1){1'b1}}, 1'b0}, ent_wen,
                           ent_dst, ent_tnew, bus.stage_wdata);
    e_rt_m = find_youngest(e_src_rt, {{(NSTAGE-1){1'b1}}, 1'b0}, ent_wen,
                           ent_dst, ent_tnew, bus.stage_wdata);
  end

  // Stall logic.
  // A source stalls D when its producer will not have the value ready
  // by the time D needs it. MDU users also wait for the counter to drain.
  // A bubble in D never stalls.
  assign rs_wait     = bus.d_rs_use && d_rs_m.hit && (d_rs_m.tnew > bus.d_rs_tuse);
  assign rt_wait     = bus.d_rt_use && d_rt_m.hit && (d_rt_m.tnew > bus.d_rt_tuse);
  assign md_busy_int = (md_cnt != '0) || bus.md_start;
  assign md_block    = bus.d_md_use && md_busy_int;
  assign stall_int   = bus.d_valid && (rs_wait || rt_wait || md_block);

  assign bus.stall   = stall_int;
  assign bus.md_busy = md_busy_int;

  // Forwarding.
  // Only a finished result (tnew == 0) is forwarded. A pending result that
  // does not stall D is picked up later by E forwarding.
  assign bus.d_rs_fwd = (bus.d_rs_use && d_rs_m.hit && d_rs_m.tnew == '0) ?
                        d_rs_m.data : bus.d_rs_rf;
  assign bus.d_rt_fwd = (bus.d_rt_use && d_rt_m.hit && d_rt_m.tnew == '0) ?
                        d_rt_m.data : bus.d_rt_rf;
  assign bus.e_rs_fwd = (e_rs_m.hit && e_rs_m.tnew == '0) ? e_rs_m.data : bus.e_rs_in;
  assign bus.e_rt_fwd = (e_rt_m.hit && e_rt_m.tnew == '0) ? e_rt_m.data : bus.e_rt_in;

  // Scoreboard shift.
  // Entries age one stage per cycle with a saturating Tnew countdown.
  // A stalled D injects a bubble into E. The oldest entry falls off
  // the end of the array.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ent_wen  <= '0;
      ent_dst  <= '0;
      ent_tnew <= '0;
      e_src_rs <= '0;
      e_src_rt <= '0;
    end else begin
      for (int s = NSTAGE - 1; s > 0; s--) begin
        ent_wen[s]  <= ent_wen[s-1];
        ent_dst[s]  <= ent_dst[s-1];
        ent_tnew[s] <= (ent_tnew[s-1] == '0) ? '0 : ent_tnew[s-1] - TW'(1);
      end
      if (stall_int) begin
        ent_wen[0]  <= 1'b0;
        ent_dst[0]  <= '0;
        ent_tnew[0] <= '0;
        e_src_rs    <= '0;
        e_src_rt    <= '0;
      end else begin
        ent_wen[0]  <= bus.d_wen && bus.d_valid;
        ent_dst[0]  <= bus.d_dst;
        ent_tnew[0] <= bus.d_tnew;
        e_src_rs    <= bus.d_rs;
        e_src_rt    <= bus.d_rt;
      end
    end
  end

  // MDU busy counter.
  // A start pulse loads the counter only when the unit is idle, so a
  // second start during an operation cannot extend the busy window.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      md_cnt <= '0;
    end else if (bus.md_start && md_cnt == '0) begin
      md_cnt <= bus.md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

endmodule
